disp_scan_ctrl: RTL and testbench

Controller for the shared 6-digit multiplexed 7-segment display. It sequences the digit scan with a programmable dwell time per digit and a blanking gap between digits to suppress ghosting. It holds the six digit segment registers, and a fixed-priority write arbiter shares them between two requesters: port A (key-entry logic) and port B (status/message source). It sits between the key/entry logic and the board's `scan`/`dout` pins, replacing free-running scan logic.

---
 rtl/disp_pkg.sv | 22 ++
 rtl/disp_wr_arb.sv | 43 ++++
 rtl/disp_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display types and constants for the multiplexed 7-segment scan
// controller and the key-entry logic.
package disp_pkg;

  localparam int DIGITS_MAX = 8;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic {SCAN_ON, SCAN_BLANK} scan_state_e;

  // Segment codes for 0-9, bit0 = seg a ... bit6 = seg g, dp off.
  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  function automatic logic [DIGITS_MAX-1:0] onehot(input logic [2:0] idx);
    logic [DIGITS_MAX-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/disp_wr_arb.sv
// Two-port fixed-priority write arbiter; a port granted this cycle sits out
// one cycle, so a held A request cannot starve B.
module disp_wr_arb
  import disp_pkg::*;
(
  input  logic       clk100khz,
  input  logic       rst_n,
  input  logic       i_a_req,
  input  logic [2:0] i_a_idx,
  input  logic [7:0] i_a_seg,
  input  logic       i_b_req,
  input  logic [2:0] i_b_idx,
  input  logic [7:0] i_b_seg,
  output logic       o_a_gnt,
  output logic       o_b_gnt,
  output logic       o_we,
  output logic [2:0] o_idx,
  output logic [7:0] o_seg
);

  logic r_a_gnt, r_b_gnt;
  logic w_a_win, w_b_win;

  assign w_a_win = i_a_req & ~r_a_gnt;
  assign w_b_win = i_b_req & ~r_b_gnt & ~w_a_win;

  always_ff @(posedge clk100khz or negedge rst_n) begin
    if (!rst_n) begin
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
    end else begin
      r_a_gnt <= w_a_win;
      r_b_gnt <= w_b_win;
    end
  end

  assign o_a_gnt = r_a_gnt;
  assign o_b_gnt = r_b_gnt;
  assign o_we    = w_a_win | w_b_win;
  assign o_idx   = w_a_win ? i_a_idx : i_b_idx;
  assign o_seg   = w_a_win ? i_a_seg : (w_b_win ? i_b_seg : SEG_BLANK);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: digit register file, dwell/blank
// scan FSM and registered scan/dout/frame_tick outputs.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int DWELL  = 16,
  parameter int BLANK  = 2
) (
  input  logic              clk100khz,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [2:0]        a_idx,
  input  logic [7:0]        a_seg,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [2:0]        b_idx,
  input  logic [7:0]        b_seg,
  output logic              b_gnt,
  output logic [DIGITS-1:0] scan,
  output logic [7:0]        dout,
  output logic              frame_tick
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_TC = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [2:0]    DIG_LAST = 3'(DIGITS - 1);

  scan_state_e       r_state, w_state_nxt;
  logic [2:0]        r_dig, w_dig_nxt, w_dig_inc;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [7:0]        r_digit [DIGITS];
  logic [DIGITS-1:0] r_scan;
  logic [7:0]        r_dout;
  logic              r_frame_tick;

  logic              w_we;
  logic [2:0]        w_idx;
  logic [7:0]        w_seg, w_rd_seg, w_disp_seg;
  logic [DIGITS_MAX-1:0] w_onehot;

  disp_wr_arb u_arb (
    .clk100khz (clk100khz),
    .rst_n     (rst_n),
    .i_a_req   (a_req),
    .i_a_idx   (a_idx),
    .i_a_seg   (a_seg),
    .i_b_req   (b_req),
    .i_b_idx   (b_idx),
    .i_b_seg   (b_seg),
    .o_a_gnt   (a_gnt),
    .o_b_gnt   (b_gnt),
    .o_we      (w_we),
    .o_idx     (w_idx),
    .o_seg     (w_seg)
  );

  // Out-of-range indices match no register, so the write is dropped.
  always_ff @(posedge clk100khz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) r_digit[i] <= SEG_BLANK;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (w_we && w_idx == 3'(i)) r_digit[i] <= w_seg;
    end
  end

  always_comb begin
    w_rd_seg = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++)
      if (r_dig == 3'(i)) w_rd_seg = r_digit[i];
  end

  // Bypass so a write to the digit about to be shown appears with its grant.
  assign w_disp_seg = (w_we && w_idx == r_dig) ? w_seg : w_rd_seg;
  assign w_dig_inc  = (r_dig == DIG_LAST) ? 3'd0 : r_dig + 3'd1;
  assign w_onehot   = onehot(r_dig);

  always_ff @(posedge clk100khz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SCAN_ON;
      r_dig   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dig   <= w_dig_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dig_nxt   = r_dig;
    w_cnt_nxt   = r_cnt + 1'b1;
    case (r_state)
      SCAN_ON: begin
        if (r_cnt == DWELL_TC) begin
          w_cnt_nxt = '0;
          if (BLANK == 0) w_dig_nxt   = w_dig_inc;
          else            w_state_nxt = SCAN_BLANK;
        end
      end
      SCAN_BLANK: begin
        if (r_cnt == BLANK_TC) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SCAN_ON;
          w_dig_nxt   = w_dig_inc;
        end
      end
      default: w_state_nxt = SCAN_ON;
    endcase
  end

  always_ff @(posedge clk100khz or negedge rst_n) begin
    if (!rst_n) begin
      r_scan       <= '0;
      r_dout       <= SEG_BLANK;
      r_frame_tick <= 1'b0;
    end else begin
      r_scan       <= (r_state == SCAN_ON) ? w_onehot[DIGITS-1:0] : '0;
      r_dout       <= (r_state == SCAN_ON) ? w_disp_seg : SEG_BLANK;
      r_frame_tick <= (r_state == SCAN_ON) && (r_dig == 3'd0) && (r_cnt == '0);
    end
  end

  assign scan       = r_scan;
  assign dout       = r_dout;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl against a time-indexed scan model
// and a request-level arbitration model.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

  localparam int DIGITS = 6;
  localparam int DWELL  = 16;
  localparam int BLANK  = 2;
  localparam int P      = DWELL + BLANK;
  localparam int FRAME  = P * DIGITS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [2:0] a_idx = '0, b_idx = '0;
  logic [7:0] a_seg = '0, b_seg = '0;
  logic       a_gnt, b_gnt, frame_tick;
  logic [DIGITS-1:0] scan;
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int         m_t = -1;
  logic [7:0] m_mem [DIGITS];
  logic       m_ga = 1'b0, m_gb = 1'b0;

  disp_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk100khz (clk), .rst_n (rst_n),
    .a_req (a_req), .a_idx (a_idx), .a_seg (a_seg), .a_gnt (a_gnt),
    .b_req (b_req), .b_idx (b_idx), .b_seg (b_seg), .b_gnt (b_gnt),
    .scan (scan), .dout (dout), .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [DIGITS-1:0] f_scan(int t);
    if (t < 0 || (t % P) >= DWELL) return '0;
    return DIGITS'(1) << ((t / P) % DIGITS);
  endfunction

  function automatic logic [7:0] f_dout(int t);
    if (t < 0 || (t % P) >= DWELL) return 8'h00;
    return m_mem[(t / P) % DIGITS];
  endfunction

  function automatic logic f_ft(int t);
    return (t >= 0) && ((t % FRAME) == 0);
  endfunction

  task automatic model_reset();
    m_t = -1; m_ga = 1'b0; m_gb = 1'b0;
    for (int i = 0; i < DIGITS; i++) m_mem[i] = 8'h00;
  endtask

  // Advance one clock, update the model from the inputs sampled at the edge.
  task automatic tick();
    logic wa, wb;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      wa = a_req && !m_ga;
      wb = b_req && !m_gb && !wa;
      if (wa && a_idx < DIGITS) m_mem[a_idx] = a_seg;
      if (wb && b_idx < DIGITS) m_mem[b_idx] = b_seg;
      m_ga = wa; m_gb = wb;
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      tick();
      n_checks++;
      if ({scan, dout, a_gnt, b_gnt, frame_tick} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: scan=%b dout=%h gnt=%b%b ft=%b, want all 0",
                 scan, dout, a_gnt, b_gnt, frame_tick);
      end
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (scan !== 6'b000001 || frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_cycle: scan=%b ft=%b, want 000001 1", scan, frame_tick);
    end
  endtask

  task automatic test_idle_scan();
    int ticks = 0;
    for (int c = 0; c < 2 * FRAME + 5; c++) begin
      tick();
      n_checks++;
      if (scan !== f_scan(m_t) || dout !== f_dout(m_t) || frame_tick !== f_ft(m_t)) begin
        n_fail++;
        $display("FAIL idle_scan t=%0d: scan=%b dout=%h ft=%b, want %b %h %b",
                 m_t, scan, dout, frame_tick, f_scan(m_t), f_dout(m_t), f_ft(m_t));
      end
      if (frame_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 2) begin
      n_fail++;
      $display("FAIL idle_frame_ticks: got %0d, want 2", ticks);
    end
  endtask

  task automatic test_single_write();
    a_req = 1'b1; a_idx = 3'd2; a_seg = 8'h5B;
    tick();
    a_req = 1'b0;
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write_gnt: a_gnt=%b b_gnt=%b, want 1 0", a_gnt, b_gnt);
    end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if (scan === 6'b000100) begin
        n_checks++;
        if (dout !== 8'h5B) begin
          n_fail++;
          $display("FAIL single_write_dout: dout=%h, want 5b", dout);
        end
      end
    end
  endtask

  task automatic test_contention();
    tick();
    a_req = 1'b1; a_idx = 3'd0; a_seg = 8'h06;
    b_req = 1'b1; b_idx = 3'd1; b_seg = 8'h4F;
    tick();
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_n1: a_gnt=%b b_gnt=%b, want 1 0", a_gnt, b_gnt);
    end
    a_req = 1'b0;
    tick();
    n_checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL contention_n2: a_gnt=%b b_gnt=%b, want 0 1", a_gnt, b_gnt);
    end
    b_req = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      n_checks++;
      if (scan !== f_scan(m_t) || dout !== f_dout(m_t)) begin
        n_fail++;
        $display("FAIL contention_scan t=%0d: scan=%b dout=%h, want %b %h",
                 m_t, scan, dout, f_scan(m_t), f_dout(m_t));
      end
    end
  endtask

  task automatic test_held();
    logic [1:0] want [4];
    int pulses = 0;
    tick();
    a_req = 1'b1; a_idx = 3'd3; a_seg = 8'h66;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (a_gnt === 1'b1) pulses++;
    end
    a_req = 1'b0;
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL held_a_pulses: got %0d, want 3", pulses);
    end
    tick(); tick();
    want = '{2'b10, 2'b01, 2'b10, 2'b01};
    a_req = 1'b1; a_idx = 3'd4; a_seg = 8'h6D;
    b_req = 1'b1; b_idx = 3'd5; b_seg = 8'h7D;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({a_gnt, b_gnt} !== want[c]) begin
        n_fail++;
        $display("FAIL held_alternate[%0d]: gnt=%b, want %b", c, {a_gnt, b_gnt}, want[c]);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_bad_index();
    tick(); tick();
    b_req = 1'b1; b_idx = 3'd7; b_seg = 8'hFF;
    tick();
    b_req = 1'b0;
    n_checks++;
    if (b_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_index_gnt: b_gnt=%b, want 1", b_gnt);
    end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      n_checks++;
      if (dout === 8'hFF || dout !== f_dout(m_t)) begin
        n_fail++;
        $display("FAIL bad_index_dout t=%0d: dout=%h, want %h", m_t, dout, f_dout(m_t));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if (!a_req) begin
        a_req = ($urandom_range(0, 2) == 0);
        a_idx = 3'($urandom_range(0, 7));
        a_seg = 8'($urandom);
      end else if (a_gnt) a_req = 1'b0;
      if (!b_req) begin
        b_req = ($urandom_range(0, 2) == 0);
        b_idx = 3'($urandom_range(0, 7));
        b_seg = 8'($urandom);
      end else if (b_gnt) b_req = 1'b0;
      tick();
      n_checks++;
      if (scan !== f_scan(m_t) || dout !== f_dout(m_t) || frame_tick !== f_ft(m_t) ||
          a_gnt !== m_ga || b_gnt !== m_gb) begin
        n_fail++;
        $display("FAIL random t=%0d: scan=%b dout=%h ft=%b gnt=%b%b, want %b %h %b %b%b",
                 m_t, scan, dout, frame_tick, a_gnt, b_gnt,
                 f_scan(m_t), f_dout(m_t), f_ft(m_t), m_ga, m_gb);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    tick(); tick();
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      if (scan === 6'b010000) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_find_digit4: scan never reached 010000");
    end
    a_req = 1'b1; a_idx = 3'd4; a_seg = 8'h77;
    tick();
    a_req = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({scan, dout, a_gnt, b_gnt, frame_tick} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_immediate: scan=%b dout=%h gnt=%b%b ft=%b, want all 0",
               scan, dout, a_gnt, b_gnt, frame_tick);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (scan !== 6'b000001 || frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: scan=%b ft=%b, want 000001 1", scan, frame_tick);
    end
    for (int c = 1; c < FRAME + 2; c++) begin
      tick();
      n_checks++;
      if (scan !== f_scan(m_t) || dout !== 8'h00 || frame_tick !== f_ft(m_t)) begin
        n_fail++;
        $display("FAIL reset_mid_scan t=%0d: scan=%b dout=%h ft=%b, want %b 00 %b",
                 m_t, scan, dout, frame_tick, f_scan(m_t), f_ft(m_t));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_single_write();
    test_contention();
    test_held();
    test_bad_index();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
